// File: rtl/led16_ctrl.sv
// led16_ctrl -- front-panel controller feeding the en/mod pins of led16_drv.
//
// Two raw push-buttons are synchronised, debounced and turned into one-cycle
// press pulses. A three-state run/pause FSM (IDLE/RUN/PAUSE) converts those
// pulses into registered en and mod levels.
//
// Parameters:
//   DB_CYCLES - synchronised cycles a button must hold a new level (>= 2)
//   TIMEOUT   - RUN-state idle limit in cycles (>= 2); only used when the
//               macro LED16_CTRL_TIMEOUT_EN is defined
//
// Optional feature macro: LED16_CTRL_TIMEOUT_EN
//   defined   : RUN returns to IDLE after TIMEOUT cycles without a press
//   undefined : RUN persists indefinitely, TIMEOUT is ignored
//
// Ports:
//   clk     in  1  system clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   btn_run in  1  raw run/pause button, active-high, asynchronous, bouncy
//   btn_mod in  1  raw mode button, active-high, asynchronous, bouncy
//   en      out 1  enable to led16_drv (registered)
//   mod     out 1  mode select to led16_drv (registered)
//   state   out 2  FSM state: IDLE=0, RUN=1, PAUSE=2 (registered)

// led16_ctrl_btn -- one button input path: 2-flop synchroniser, debouncer
// and rising-edge press detector.
//
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   btn   in  1  raw asynchronous button
//   press out 1  one-cycle pulse when the debounced level rises
module led16_ctrl_btn #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db;
    logic          db_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_q <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_q <= db;
            // Any cycle where the synchronised level agrees with the accepted
            // level restarts the count, so short glitches are discarded.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Rising edge of the debounced level only; releases give no pulse.
    assign press = db & ~db_q;

endmodule

module led16_ctrl #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_mod,
    output logic       en,
    output logic       mod,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t st;
    logic   pr;
    logic   pm;

    led16_ctrl_btn #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .press (pr)
    );

    led16_ctrl_btn #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mod),
        .press (pm)
    );

`ifdef LED16_CTRL_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    logic [TW-1:0] idle_cnt;
    logic          expire;

    assign expire = (st == RUN) && (idle_cnt == TO_MAX);

    // Counts idle cycles while in RUN; any press, any other state, or the
    // expiry itself returns it to zero, so entry to RUN always starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if ((st == RUN) && !pr && !pm && !expire) begin
            idle_cnt <= idle_cnt + TW'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    logic expire;

    assign expire = 1'b0;

    // TIMEOUT has no effect in this build; this empty block only references
    // it so the parameter list stays identical across builds.
    if (TIMEOUT < 2) begin : g_timeout_unused
    end
`endif

    // Single registered FSM; en/mod change only on the edge where the FSM
    // transitions or acts. A run press always beats a mode press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= IDLE;
            en  <= 1'b0;
            mod <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (pr) begin
                        st <= RUN;
                        en <= 1'b1;
                    end else if (pm) begin
                        mod <= ~mod;
                    end
                end
                RUN: begin
                    if (pr) begin
                        st <= PAUSE;
                        en <= 1'b0;
                    end else if (pm) begin
                        mod <= ~mod;
                    end else if (expire) begin
                        st <= IDLE;
                        en <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (pr) begin
                        st <= RUN;
                        en <= 1'b1;
                    end else if (pm) begin
                        st  <= IDLE;
                        mod <= 1'b0;
                    end
                end
                default: begin
                    st  <= IDLE;
                    en  <= 1'b0;
                    mod <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_led16_ctrl.sv
// tb_led16_ctrl -- self-checking bench for led16_ctrl.
// A behavioural model derives the debounced levels from the history of raw
// samples and applies the FSM rules; a compare process checks en/mod/state
// after every clock edge. Directed sequences with literal expectations pin
// the model, followed by randomized button activity.
module tb_led16_ctrl;

    localparam int DB = 4;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_mod = 1'b0;
    logic       en;
    logic       mod;
    logic [1:0] state;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    led16_ctrl #(
        .DB_CYCLES (DB),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_run (btn_run),
        .btn_mod (btn_mod),
        .en      (en),
        .mod     (mod),
        .state   (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit hist [2][64];   // raw samples per edge since reset release
    int n;              // edges since reset release
    bit mdb  [2];       // debounced level after previous edge
    bit mdbq [2];       // debounced level one edge earlier
    int mst;            // 0 idle, 1 run, 2 pause
    bit mmod;
    int mto;            // idle cycles spent in RUN

    function automatic bit raw_at(input int b, input int k);
        if (k < 0) return 1'b0;
        return hist[b][k % 64];
    endfunction

    // The debounced level changes at edge n when the synchronised level seen
    // over the last DB edges (raw delayed by two) all differed from it.
    function automatic bit will_flip(input int b);
        for (int j = n - DB; j < n; j++)
            if (raw_at(b, j - 1) == mdb[b]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        n = 0; mst = 0; mmod = 0; mto = 0;
        for (int b = 0; b < 2; b++) begin
            mdb[b] = 0; mdbq[b] = 0;
        end
    endtask

    task automatic model_edge(input bit rr, input bit rm);
        bit pr, pm, f;
        hist[0][n % 64] = rr;
        hist[1][n % 64] = rm;
        pr = mdb[0] && !mdbq[0];
        pm = mdb[1] && !mdbq[1];
        case (mst)
            0: if (pr) begin mst = 1; mto = 0; end
               else if (pm) mmod = !mmod;
            1: if (pr) mst = 2;
               else if (pm) begin mmod = !mmod; mto = 0; end
               else begin
`ifdef LED16_CTRL_TIMEOUT_EN
                   if (mto == TO - 1) mst = 0;
                   else mto++;
`endif
               end
            default: if (pr) begin mst = 1; mto = 0; end
                     else if (pm) begin mst = 0; mmod = 0; end
        endcase
        for (int b = 0; b < 2; b++) begin
            f = will_flip(b);
            mdbq[b] = mdb[b];
            if (f) mdb[b] = !mdb[b];
        end
        n++;
    endtask

    // ---------------- compare process ----------------
    initial begin
        bit rr, rm;
        model_reset();
        forever begin
            @(posedge clk);
            rr = btn_run;
            rm = btn_mod;
            if (!rst_n) begin
                model_reset();
            end else begin
                model_edge(rr, rm);
                #1;
                chk("model_en", int'(en), int'(mst == 1));
                chk("model_mod", int'(mod), int'(mmod));
                chk("model_state", int'(state), mst);
            end
        end
    end

    task automatic press(input int b);
        @(negedge clk);
        if (b == 0) btn_run = 1'b1; else btn_mod = 1'b1;
        repeat (DB + 4) @(negedge clk);
        btn_run = 1'b0;
        btn_mod = 1'b0;
        repeat (DB + 6) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rem [2];
        repeat (3) @(negedge clk);
        chk("reset_en", int'(en), 0);
        chk("reset_mod", int'(mod), 0);
        chk("reset_state", int'(state), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press: en rises at edge DB+2 and stays while held.
        btn_run = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            if (k == DB + 1) chk("clean_en_before", int'(en), 0);
            if (k == DB + 2) begin
                chk("clean_en_rise", int'(en), 1);
                chk("clean_state", int'(state), 1);
            end
        end
        chk("clean_held_state", int'(state), 1);
        @(negedge clk);
        btn_run = 1'b0;
        repeat (DB + 6) @(negedge clk);

        // Mode toggles in RUN, then pause, then mode returns to IDLE.
        press(1);
        chk("mode1_mod", int'(mod), 1);
        chk("mode1_en", int'(en), 1);
        press(1);
        chk("mode2_mod", int'(mod), 0);
        press(1);
        chk("mode3_mod", int'(mod), 1);
        press(0);
        chk("pause_state", int'(state), 2);
        chk("pause_en", int'(en), 0);
        press(1);
        chk("pause_mod_state", int'(state), 0);
        chk("pause_mod_mod", int'(mod), 0);

        // Bounce rejection: glitches of 1, 2 and 3 cycles.
        for (int len = 1; len <= 3; len++) begin
            @(negedge clk);
            btn_run = 1'b1;
            repeat (len) @(negedge clk);
            btn_run = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (DB + 4) @(negedge clk);
        chk("bounce_en", int'(en), 0);
        chk("bounce_state", int'(state), 0);

        // Simultaneous rise from IDLE: run wins, mod unchanged.
        btn_run = 1'b1;
        btn_mod = 1'b1;
        for (int k = 0; k <= DB + 2; k++) begin
            @(posedge clk); #2;
        end
        chk("simul_state", int'(state), 1);
        chk("simul_mod", int'(mod), 0);
        @(negedge clk);
        btn_run = 1'b0;
        btn_mod = 1'b0;
        repeat (DB + 6) @(negedge clk);
        chk("simul_en", int'(en), 1);

        // Asynchronous reset mid-run.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_en", int'(en), 0);
        chk("async_mod", int'(mod), 0);
        chk("async_state", int'(state), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_en", int'(en), 0);
        chk("post_reset_state", int'(state), 0);

        // Enter RUN (edge DB+2 = 6), mod press acts at edge 30.
        for (int k = 0; k <= 85; k++) begin
            @(negedge clk);
            btn_run = (k < 8);
            btn_mod = (k >= 24 && k < 32);
            @(posedge clk); #2;
            if (k == 6) chk("to_entry_en", int'(en), 1);
            if (k == 30) chk("to_mod_mod", int'(mod), 1);
`ifdef LED16_CTRL_TIMEOUT_EN
            if (k == 56) chk("to_delayed_en", int'(en), 1);
            if (k == 79) chk("to_last_en", int'(en), 1);
            if (k == 80) begin
                chk("to_expire_en", int'(en), 0);
                chk("to_expire_state", int'(state), 0);
                chk("to_expire_mod", int'(mod), 1);
            end
`else
            if (k == 85) chk("no_to_en", int'(en), 1);
`endif
        end

        // Randomized button activity with one reset in the middle.
        rem[0] = 1;
        rem[1] = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (i == 3000) rst_n = 1'b0;
            if (i == 3003) rst_n = 1'b1;
            for (int b = 0; b < 2; b++) begin
                rem[b]--;
                if (rem[b] <= 0) begin
                    if (b == 0) btn_run = !btn_run; else btn_mod = !btn_mod;
                    rem[b] = $urandom_range(1, 3 * DB);
                end
            end
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
